int_div_iter_unsigned: RTL and testbench
========================================

# int_div_iter_unsigned

Iterative unsigned 32-bit integer divider that produces a quotient and remainder over val/rdy stream interfaces. It is the inverse companion of the iterative multiplier in the arithmetic-unit lab and accepts the same 64-bit operand-pair message format. Latency is fixed, using one restoring-division step per cycle, so throughput is one transaction per 34 cycles plus any output backpressure. It is intended to sit behind the processor's div/rem functional-unit port.

## Interface
- Parameters: none. Width is fixed at 32-bit operands and a 64-bit result.
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- istream_val  in  1  operand message valid
- istream_rdy  out  1  divider can accept an operand message
- istream_msg  in  64  [63:32] dividend A, [31:0] divisor B, both unsigned
- ostream_val  out  1  result valid
- ostream_rdy  in  1  consumer accepts result
- ostream_msg  out  64  [63:32] remainder R, [31:0] quotient Q

## Operation
- States:
  - IDLE: istream_rdy=1, ostream_val=0.
  - CALC: istream_rdy=0, ostream_val=0.
  - DONE: istream_rdy=0, ostream_val=1.
- Transitions:
  - IDLE→CALC when istream_val is high (fire).
  - CALC→DONE when the step counter equals 31 at the clock edge.
  - DONE→IDLE when ostream_rdy is high.
  - All other cases hold the current state.
- On fire:
  - Load the 64-bit working register W = {32'b0, A}.
  - Load the divisor register D = B.
  - Clear the 5-bit counter.
- Each CALC cycle:
  - Compute S = W[62:31] − D as a 33-bit subtraction with borrow, i.e. {1'b0, W[62:31]} − {1'b0, D}.
  - If there is no borrow: W ← {S[31:0], W[30:0], 1'b1}.
  - If there is a borrow: W ← {W[62:0], 1'b0}.
  - Increment the counter.
- After 32 steps, W[63:32] = R and W[31:0] = Q. ostream_msg is driven directly from W.
- All arithmetic is modulo 2^32 except the 33-bit trial subtraction. There are no signed semantics.
- Divide by zero is not special-cased:
  - Every step succeeds, giving Q = 0xFFFFFFFF and R = A.
  - This matches the RISC-V M-extension divu/remu results.
- A=0 yields Q=0, R=0. A<B yields Q=0, R=A.
- The result is held in W, unchanged, throughout DONE regardless of ostream_rdy.

## Timing
- Reset values: state=IDLE, istream_rdy=1, ostream_val=0, W=0 (so ostream_msg=0), D=0, counter=0.
- Reset takes effect asynchronously, mid-CALC or mid-DONE. The in-flight transaction is discarded, with no output.
- Latency:
  - Fire on edge T.
  - CALC covers edges T+1 … T+32.
  - ostream_val rises in the cycle after edge T+32.
  - This gives 33 cycles from the accept edge to ostream_val.
- The output transfer occurs on the edge where ostream_val and ostream_rdy are both high. istream_rdy returns high in the following cycle.
- There is no overlap: a new operand cannot be accepted in the same cycle as the output transfer. The minimum initiation interval is 34 cycles.
- istream_rdy depends only on state, never on istream_val, so there is no combinational val→rdy path. ostream_val likewise depends only on state.
- istream_msg is sampled only on the fire edge. Later changes to it are ignored.

## Structure
- Shared package int_div_pkg holds:
  - the state_e enum (IDLE, CALC, DONE; 2-bit);
  - constants DIV_NBITS=32 and DIV_LAST_STEP=5'd31.
- One sub-module, int_div_iter_dpath, contains:
  - the W, D and counter registers;
  - the 33-bit subtractor and the step mux.
  - It exports borrow and count_done, and takes the load and step controls.
- The FSM and the line-trace live in the top module int_div_iter_unsigned.

## Test plan
- A=100, B=7 → ostream_msg=0x00000002_0000000E, with ostream_val rising 33 cycles after the accept edge.
- A=5, B=0 → 0x00000005_FFFFFFFF. A=0xFFFFFFFF, B=1 → 0x00000000_FFFFFFFF.
- A=3, B=10 → 0x00000003_00000000. A=0x80000000, B=0x80000000 → 0x00000000_00000001.
- Hold ostream_rdy low for 5 cycles in DONE:
  - ostream_val and ostream_msg stay stable;
  - istream_rdy stays 0;
  - the transfer happens on the first rdy-high edge.
- Streaming source with istream_val always high, 10 random operand pairs, sink always ready:
  - every result matches the golden A/B and A%B;
  - the initiation interval is exactly 34 cycles.
- Assert reset at CALC step 10:
  - istream_rdy=1 and ostream_val=0 immediately;
  - a subsequent A=100, B=7 completes correctly.

Source files
------------

// File: rtl/int_div_pkg.sv
// Shared types and constants for the iterative unsigned divider.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package int_div_pkg;

   localparam int         DIV_NBITS     = 32;
   localparam logic [4:0] DIV_LAST_STEP = 5'd31;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   // Operand message: dividend in the upper half, divisor in the lower half.
   typedef struct packed {
      logic [DIV_NBITS-1:0] a;
      logic [DIV_NBITS-1:0] b;
   } div_req_t;

   // Result message: remainder in the upper half, quotient in the lower half.
   typedef struct packed {
      logic [DIV_NBITS-1:0] rem;
      logic [DIV_NBITS-1:0] quo;
   } div_resp_t;

endpackage

// File: rtl/int_div_iter_dpath.sv
// Restoring-division datapath: W/D/counter registers, trial subtractor, step mux.
// Latency: one restoring step per asserted step cycle; 32 steps give R:Q in W.
// Backpressure: none internally; W holds its value whenever load and step are low.
module int_div_iter_dpath
   import int_div_pkg::*;
(
   input  logic      clk,
   input  logic      reset,
   input  logic      load,
   input  logic      step,
   input  div_req_t  req,
   output div_resp_t resp,
   output logic      borrow,
   output logic      count_done
);

   logic [2*DIV_NBITS-1:0] w_q;
   logic [DIV_NBITS-1:0]   d_q;
   logic [4:0]             cnt_q;
   logic [DIV_NBITS:0]     diff;
   logic [2*DIV_NBITS-1:0] w_step;

   // Trial subtraction of the divisor from the shifted partial remainder.
   // W[63] is always zero before a step (the partial remainder after k steps
   // is below 2^k), so W[62:31] is the full shifted remainder.
   always_comb begin
      diff   = {1'b0, w_q[2*DIV_NBITS-2:DIV_NBITS-1]} - {1'b0, d_q};
      borrow = diff[DIV_NBITS];
      if (borrow) begin
         w_step = {w_q[2*DIV_NBITS-2:0], 1'b0};
      end else begin
         w_step = {diff[DIV_NBITS-1:0], w_q[DIV_NBITS-2:0], 1'b1};
      end
   end

   // Working, divisor and step-count registers: load on accept, shift on step.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         w_q   <= '0;
         d_q   <= '0;
         cnt_q <= '0;
      end else if (load) begin
         w_q   <= {{DIV_NBITS{1'b0}}, req.a};
         d_q   <= req.b;
         cnt_q <= '0;
      end else if (step) begin
         w_q   <= w_step;
         cnt_q <= cnt_q + 5'd1;
      end
   end

   assign count_done = (cnt_q == DIV_LAST_STEP);
   assign resp       = w_q;

endmodule

// File: rtl/int_div_iter_unsigned.sv
// Iterative 32-bit unsigned divider, quotient and remainder over val/rdy streams.
// Latency: ostream_val rises after the 32nd edge following the accept edge; II = 34.
// Backpressure: result held in DONE until ostream_rdy; no new accept until then.
module int_div_iter_unsigned
   import int_div_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        istream_val,
   output logic        istream_rdy,
   input  logic [63:0] istream_msg,
   output logic        ostream_val,
   input  logic        ostream_rdy,
   output logic [63:0] ostream_msg
);

   state_e    state_q;
   state_e    state_d;
   logic      load;
   logic      step;
   logic      borrow;
   logic      count_done;
   div_req_t  req;
   div_resp_t resp;

   assign req         = istream_msg;
   assign ostream_msg = resp;

   // Control state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and control outputs; handshake outputs depend on state only.
   always_comb begin
      state_d     = state_q;
      load        = 1'b0;
      step        = 1'b0;
      istream_rdy = 1'b0;
      ostream_val = 1'b0;
      case (state_q)
         IDLE: begin
            istream_rdy = 1'b1;
            if (istream_val) begin
               load    = 1'b1;
               state_d = CALC;
            end
         end
         CALC: begin
            step = 1'b1;
            if (count_done) begin
               state_d = DONE;
            end
         end
         DONE: begin
            ostream_val = 1'b1;
            if (ostream_rdy) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   int_div_iter_dpath u_dpath (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .step       (step),
      .req        (req),
      .resp       (resp),
      .borrow     (borrow),
      .count_done (count_done)
   );

   // The step decision must be a known value whenever a step is being taken.
   a_borrow_known: assert property (@(posedge clk) disable iff (reset)
      (state_q == CALC) |-> !$isunknown(borrow));

endmodule

// File: tb/tb_int_div_iter_unsigned.sv
// Scoreboard bench for int_div_iter_unsigned: driver pushes expectations, monitor pops.
// Latency: checks 32 edges from accept edge to first visible ostream_val, II of 34.
// Backpressure: exercises held results under ostream_rdy low and mid-CALC reset.
module tb_int_div_iter_unsigned;

   logic        clk;
   logic        reset;
   logic        istream_val;
   logic        istream_rdy;
   logic [63:0] istream_msg;
   logic        ostream_val;
   logic        ostream_rdy;
   logic [63:0] ostream_msg;

   int          n_vec;
   int          n_err;
   int          edge_cnt;
   int          last_fire;
   logic [63:0] exp_q[$];
   int          fire_q[$];

   int_div_iter_unsigned dut (
      .clk         (clk),
      .reset       (reset),
      .istream_val (istream_val),
      .istream_rdy (istream_rdy),
      .istream_msg (istream_msg),
      .ostream_val (ostream_val),
      .ostream_rdy (ostream_rdy),
      .ostream_msg (ostream_msg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_bound(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
   endtask

   // Golden divu/remu result packed as {R, Q}.
   function automatic logic [63:0] golden(input logic [31:0] a, input logic [31:0] b);
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      return {a % b, a / b};
   endfunction

   // Offer one operand pair; returns 1ns after the accept edge.
   task automatic send(input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input bit keep_val, input bit chk_ii);
      int n;
      n = 0;
      istream_val = 1'b1;
      istream_msg = {a, b};
      while (!istream_rdy && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!istream_rdy) begin
         fail_bound("accept_wait");
         istream_val = 1'b0;
         return;
      end
      exp_q.push_back(exp);
      fire_q.push_back(edge_cnt + 1);
      if (chk_ii) check64("init_interval", 64'(edge_cnt + 1 - last_fire), 64'd34);
      last_fire = edge_cnt + 1;
      @(posedge clk);
      #1;
      if (!keep_val) begin
         istream_val = 1'b0;
         istream_msg = 64'hDEAD_BEEF_0BAD_F00D;
      end
   endtask

   // Monitor: latency on rise, stability while held, result on transfer.
   initial begin : monitor
      logic        val_prev;
      logic        xfer_prev;
      logic [63:0] held;
      val_prev  = 1'b0;
      xfer_prev = 1'b0;
      held      = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            val_prev  = 1'b0;
            xfer_prev = 1'b0;
         end else begin
            if (xfer_prev) begin
               check64("post_xfer_val", {63'd0, ostream_val}, 64'd0);
               check64("post_xfer_irdy", {63'd0, istream_rdy}, 64'd1);
            end
            if (ostream_val) begin
               if (!val_prev) begin
                  held = ostream_msg;
                  if (fire_q.size() == 0) fail_bound("latency_no_fire");
                  else check64("latency", 64'(edge_cnt - fire_q[0]), 64'd32);
               end else begin
                  check64("hold_msg", ostream_msg, held);
                  check64("hold_irdy", {63'd0, istream_rdy}, 64'd0);
               end
               if (ostream_rdy) begin
                  if (exp_q.size() == 0) begin
                     fail_bound("spurious_result");
                  end else begin
                     check64("result", ostream_msg, exp_q.pop_front());
                     void'(fire_q.pop_front());
                  end
               end
            end
            val_prev  = ostream_val;
            xfer_prev = ostream_val && ostream_rdy;
         end
      end
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
   } vec_t;

   vec_t dir_vecs[6];

   initial begin : driver
      int n;
      logic [31:0] ra;
      logic [31:0] rb;
      n_vec       = 0;
      n_err       = 0;
      edge_cnt    = 0;
      last_fire   = 0;
      reset       = 1'b1;
      istream_val = 1'b0;
      istream_msg = '0;
      ostream_rdy = 1'b1;

      dir_vecs[0] = '{32'd100,        32'd7,          64'h00000002_0000000E};
      dir_vecs[1] = '{32'd5,          32'd0,          64'h00000005_FFFFFFFF};
      dir_vecs[2] = '{32'hFFFF_FFFF,  32'd1,          64'h00000000_FFFFFFFF};
      dir_vecs[3] = '{32'd3,          32'd10,         64'h00000003_00000000};
      dir_vecs[4] = '{32'h8000_0000,  32'h8000_0000,  64'h00000000_00000001};
      dir_vecs[5] = '{32'd0,          32'd5,          64'h00000000_00000000};

      repeat (2) @(posedge clk);
      #1;
      check64("reset_irdy", {63'd0, istream_rdy}, 64'd1);
      check64("reset_oval", {63'd0, ostream_val}, 64'd0);
      check64("reset_msg", ostream_msg, 64'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Directed vectors, sink always ready.
      foreach (dir_vecs[i]) send(dir_vecs[i].a, dir_vecs[i].b, dir_vecs[i].exp, 1'b0, 1'b0);

      // Output backpressure: five DONE cycles with ostream_rdy low.
      n = 0;
      while (!istream_rdy && n < 200) begin @(posedge clk); #1; n++; end
      ostream_rdy = 1'b0;
      send(32'd1000, 32'd33, 64'h0000000A_0000001E, 1'b0, 1'b0);
      n = 0;
      while (!ostream_val && n < 100) begin @(posedge clk); #1; n++; end
      if (!ostream_val) fail_bound("hold_wait_val");
      repeat (4) @(posedge clk);
      #1;
      check64("hold_still_valid", {63'd0, ostream_val}, 64'd1);
      ostream_rdy = 1'b1;
      @(posedge clk);
      #1;

      // Streaming source, istream_val kept high, 10 pseudo-random pairs.
      for (int k = 0; k < 10; k++) begin
         ra = $urandom;
         rb = $urandom >> $urandom_range(0, 31);
         if (k == 3) rb = 32'd0;
         send(ra, rb, golden(ra, rb), 1'b1, k != 0);
      end
      istream_val = 1'b0;

      // Reset during CALC step 10 discards the transaction.
      n = 0;
      while (!istream_rdy && n < 200) begin @(posedge clk); #1; n++; end
      send(32'd77, 32'd3, golden(32'd77, 32'd3), 1'b0, 1'b0);
      repeat (9) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check64("rst_mid_irdy", {63'd0, istream_rdy}, 64'd1);
      check64("rst_mid_oval", {63'd0, ostream_val}, 64'd0);
      exp_q.delete();
      fire_q.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      send(32'd100, 32'd7, 64'h00000002_0000000E, 1'b0, 1'b0);

      // Drain the scoreboard.
      n = 0;
      while (exp_q.size() != 0 && n < 500) begin @(posedge clk); #1; n++; end
      if (exp_q.size() != 0) fail_bound("drain");
      repeat (3) @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
